// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked MIPS ALU with registered results; `ALU_PIPE_MUL_EN builds the iterative multiplier
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_1,
    input  logic [WIDTH-1:0]   in_2,
    input  logic [3:0]         alu_control,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               zero_signal,
    output logic               ovf,
    output logic               illegal,
    output logic               busy
);
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic             res_ovf;
    logic             res_ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             is_mul;

    assign sum  = in_1 + in_2;
    assign diff = in_1 - in_2;

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_ill = 1'b0;
        case (alu_control)
            4'b0010, 4'b0011, 4'b1000, 4'b1001: begin
                res     = sum;
                res_ovf = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (sum[WIDTH-1] != in_1[WIDTH-1]);
            end
            4'b0110: begin
                res     = diff;
                res_ovf = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (diff[WIDTH-1] != in_1[WIDTH-1]);
            end
            4'b0000, 4'b0001: res = in_1 & in_2;
            4'b1100:          res = ~(in_1 | in_2);
            4'b0100:          res = in_1 << shamt;
            4'b0101:          res = in_1 >> shamt;
            4'b0111:          res = {{(WIDTH-1){1'b0}}, ($signed(in_1) < $signed(in_2))};
            4'b1010:          res = '0;
            4'b1011, 4'b1111: res = in_1;
            // 1110 always; 1101 also lands here when the multiplier is not built
            default:          res_ill = 1'b1;
        endcase
        res_zero = (alu_control == 4'b1010) ? (in_1 == in_2) : (res == '0);
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign is_mul   = (alu_control == 4'b1101);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign busy     = (state == MUL);
`else
    assign is_mul   = 1'b0;
    assign in_ready = !out_valid || out_ready;
    assign busy     = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out         <= '0;
            zero_signal <= 1'b0;
            ovf         <= 1'b0;
            illegal     <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state  <= IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !is_mul) begin
                out         <= res;
                zero_signal <= res_zero;
                ovf         <= res_ovf;
                illegal     <= res_ill;
                out_valid   <= 1'b1;
            end
`ifdef ALU_PIPE_MUL_EN
            if (state == IDLE) begin
                if (accept && is_mul) begin
                    mcand  <= in_1;
                    mplier <= in_2;
                    acc    <= '0;
                    count  <= CNT_W'(WIDTH);
                    state  <= MUL;
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CNT_W'(1);
                // last iteration: publish the sum including this step's partial product
                if (count == CNT_W'(1)) begin
                    out         <= acc_next;
                    zero_signal <= (acc_next == '0);
                    ovf         <= 1'b0;
                    illegal     <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= IDLE;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe against a behavioural model
module tb_alu_pipe;
    localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] val;
        logic         zero;
        logic         ovf;
        logic         ill;
    } res_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_1;
    logic [W-1:0] in_2;
    logic [3:0]   alu_control;
    logic [4:0]   shamt;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_d;
    logic         zero_signal;
    logic         ovf;
    logic         illegal;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_pipe #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_1(in_1), .in_2(in_2), .alu_control(alu_control), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out(out_d),
        .zero_signal(zero_signal), .ovf(ovf), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic res_t model_op(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [4:0] sh);
        longint sa, sb, s;
        longint unsigned p;
        res_t r;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd2, 4'd3, 4'd8, 4'd9: begin
                s = sa + sb; r.val = a + b;
                r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s = sa - sb; r.val = a - b;
                r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd0, 4'd1: r.val = a & b;
            4'd12:      r.val = ~(a | b);
            4'd4:       r.val = a << sh;
            4'd5:       r.val = a >> sh;
            4'd7:       r.val = (sa < sb) ? 1 : 0;
            4'd10:      r.val = 0;
            4'd11, 4'd15: r.val = a;
            4'd13: begin
                if (MUL_EN) begin
                    p = 64'(a) * 64'(b);
                    r.val = p[W-1:0];
                end else r.ill = 1'b1;
            end
            default: r.ill = 1'b1;
        endcase
        r.zero = (op == 4'd10) ? (a == b) : (r.val == 0);
        return r;
    endfunction

    // model of what the block must be presenting after each edge
    bit   m_valid = 1'b0;
    int   m_left  = 0;
    res_t m_res, m_mul;
    int   acc_cnt = 0;
    int   dlv_cnt = 0;

    always @(negedge clk) begin
        logic exp_ready;
        res_t r;
        if (reset) begin
            m_valid = 1'b0;
            m_left  = 0;
            dlv_cnt = acc_cnt;
        end else begin
            exp_ready = (m_left == 0) && (!m_valid || out_ready);
            check("in_ready", in_ready, exp_ready);
            check("busy", busy, m_left != 0);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("out", out_d, m_res.val);
                check("zero_signal", zero_signal, m_res.zero);
                check("ovf", ovf, m_res.ovf);
                check("illegal", illegal, m_res.ill);
            end
            if (out_valid && out_ready) dlv_cnt++;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_mul;
                end
            end
            if (in_valid && exp_ready) begin
                acc_cnt++;
                r = model_op(alu_control, in_1, in_2, shamt);
                if (MUL_EN && alu_control == 4'd13) begin
                    m_left = W;
                    m_mul  = r;
                end else begin
                    m_valid = 1'b1;
                    m_res   = r;
                end
            end
        end
    end

    task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] e_out,
                         input logic e_zero, input logic e_ovf, input logic e_ill, input int e_lat);
        bit got;
        int lat;
        @(posedge clk); #2;
        in_valid = 1'b1; alu_control = op; in_1 = a; in_2 = b; shamt = sh; out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check({nm, "_accept"}, got, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0; in_1 = $urandom; in_2 = $urandom;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        check({nm, "_latency"}, lat, e_lat);
        check({nm, "_out"}, out_d, e_out);
        check({nm, "_zero"}, zero_signal, e_zero);
        check({nm, "_ovf"}, ovf, e_ovf);
        check({nm, "_illegal"}, illegal, e_ill);
    endtask

    task automatic mul_test();
        bit got, rdy_seen;
        int lat;
        @(posedge clk); #2;
        in_valid = 1'b1; alu_control = 4'd13; in_1 = 32'h0000FFFF; in_2 = 32'h00010001; out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("mul1_accept", got, 1'b1);
        @(posedge clk); #2;
        in_1 = 3; in_2 = 5;
        got = 1'b0; lat = 0; rdy_seen = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
            else if (in_ready) rdy_seen = 1'b1;
        end
        check("mul1_latency", lat, W);
        check("mul1_in_ready_low", rdy_seen, 1'b0);
        check("mul1_out", out_d, 32'hFFFFFFFF);
        check("mul1_ready_on_done", in_ready, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        got = 1'b0; lat = 0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
        end
        check("mul2_latency", lat, W);
        check("mul2_out", out_d, 32'd15);
    endtask

    task automatic bp_test();
        logic [W-1:0] got [4];
        int ng, ni;
        bit acc;
        ng = 0; ni = 0;
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; alu_control = 4'd2; in_1 = 32'h1000; in_2 = 1; shamt = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) check("bp_in_ready_held", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                got[ng] = out_d;
                ng++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #2;
            if (acc) begin
                ni++;
                if (ni == 4) in_valid = 1'b0;
                else in_1 = 32'h1000 + ni;
            end
            out_ready = (c >= 3);
        end
        check("bp_count", ng, 4);
        for (int i = 0; i < 4; i++) check("bp_order", got[i], 32'h1001 + i);
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_1 = '0; in_2 = '0; alu_control = '0; shamt = '0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out_d, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        #21 reset = 1'b0;
        #1 check("rst_in_ready", in_ready, 1'b1);

        do_op("add_ovf", 4'd2, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, 0, 1);
        do_op("sub_zero", 4'd6, 5, 5, 0, 0, 1, 0, 0, 1);
        do_op("sub_ovf", 4'd6, 32'h80000000, 1, 0, 32'h7FFFFFFF, 0, 1, 0, 1);
        do_op("slt_neg", 4'd7, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 1);
        do_op("and", 4'd0, 32'hF0F0, 32'h0FF0, 0, 32'h00F0, 0, 0, 0, 1);
        do_op("nor", 4'd12, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
        do_op("sll31", 4'd4, 1, 0, 31, 32'h80000000, 0, 0, 0, 1);
        do_op("sll0", 4'd4, 32'h1234, 0, 0, 32'h1234, 0, 0, 0, 1);
        do_op("srl31", 4'd5, 32'h80000000, 0, 31, 1, 0, 0, 0, 1);
        do_op("beq_eq", 4'd10, 32'h1234, 32'h1234, 0, 0, 1, 0, 0, 1);
        do_op("beq_ne", 4'd10, 32'h1234, 32'h1235, 0, 0, 0, 0, 0, 1);
        do_op("jal", 4'd11, 32'hABCD, 7, 0, 32'hABCD, 0, 0, 0, 1);
        do_op("ill_1110", 4'd14, 9, 9, 0, 0, 1, 0, 1, 1);
        if (MUL_EN) mul_test();
        else do_op("mul_absent", 4'd13, 3, 5, 0, 0, 1, 0, 1, 1);
        bp_test();

        // reset during a multiply (or a held result) must discard it immediately
        @(posedge clk); #2;
        in_valid = 1'b1; alu_control = MUL_EN ? 4'd13 : 4'd2; in_1 = 7; in_2 = 9; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out", out_d, 0);
        check("midrst_zero", zero_signal, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        @(negedge clk);
        @(posedge clk); #2 reset = 1'b0; out_ready = 1'b1;
        #1 check("midrst_in_ready", in_ready, 1'b1);
        repeat (40) @(posedge clk);

        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            in_valid    = ($urandom_range(0, 3) != 0);
            alu_control = 4'($urandom_range(0, 15));
            if (alu_control == 4'd13 && $urandom_range(0, 3) != 0) alu_control = 4'd2;
            in_1      = rand_operand();
            in_2      = rand_operand();
            shamt     = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("drain_out_valid", out_valid, 1'b0);
        check("accepted_vs_delivered", acc_cnt, dlv_cnt);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
